// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//   It keeps a 3-entry destination scoreboard (EX/MEM/WB) and detects RAW
//   hazards against the ID-stage sources. It also turns EX redirects into
//   flushes and freezes the pipe while a DRAM access is outstanding.
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   id_*                   ID-stage instruction fields from the decoder
//   ex_redirect            taken branch / jal / jalr resolved in EX
//   mem_req, mem_ack       DRAM handshake of the MEM-stage instruction
//   stall_pc, stall_if_id  hold PC / IF/ID register
//   flush_if_id            clear IF/ID to a bubble
//   flush_id_ex            insert a bubble into ID/EX
//   freeze                 hold every pipeline register
//   mem_timeout            one-cycle pulse when a DRAM wait is aborted
//   stall_cnt, flush_cnt   saturating event counters
module pipeline_hazard_ctrl #(
  parameter int FORWARD_EN  = 1,
  parameter int RF_BYPASS   = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_re,
  input  logic        id_rs2_re,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_we,
  input  logic        id_is_load,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        freeze,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam int         CW      = $clog2(MEM_TIMEOUT + 2);

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;

  // A valid entry always has rd != 0, so x0 can never match.
  // Only the EX entry's load flag matters: a load in MEM has its data ready
  // for forwarding, so is_load is not carried further down.
  logic          ex_vld_p0, mem_vld_p1, wb_vld_p2;
  logic [4:0]    ex_rd_p0, mem_rd_p1, wb_rd_p2;
  logic          ex_ld_p0;

  logic id_ent_vld, m_ex, m_mem, m_wb, hazard, frz, timeout_hit, ex_next_vld;

  function automatic logic src_match(input logic vld, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic re1, input logic re2);
    return vld & ((re1 & (rs1 == rd)) | (re2 & (rs2 == rd)));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    id_ent_vld  = id_valid & id_rf_we & (id_rd != 5'd0);
    m_ex        = id_valid & src_match(ex_vld_p0,  ex_rd_p0,  id_rs1, id_rs2, id_rs1_re, id_rs2_re);
    m_mem       = id_valid & src_match(mem_vld_p1, mem_rd_p1, id_rs1, id_rs2, id_rs1_re, id_rs2_re);
    m_wb        = id_valid & src_match(wb_vld_p2,  wb_rd_p2,  id_rs1, id_rs2, id_rs1_re, id_rs2_re);
    if (FORWARD_EN != 0) hazard = m_ex & ex_ld_p0;
    else                 hazard = m_ex | m_mem | (m_wb & (RF_BYPASS == 0));
    timeout_hit = (MEM_TIMEOUT != 0) && (state == ST_WAIT) && !mem_ack &&
                  (wait_cnt == CW'(MEM_TIMEOUT));
    // Combinational so the ack cycle itself is already released.
    frz         = ((state == ST_IDLE) & mem_req & !mem_ack) |
                  ((state == ST_WAIT) & !mem_ack & !timeout_hit);
    ex_next_vld = id_ent_vld & !ex_redirect & !hazard;
  end

  // Outputs are gated by rst so that asserting reset clears them at once,
  // even while the inputs are still requesting a freeze or a flush.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze      = 1'b0;
    mem_timeout = 1'b0;
    if (!rst) begin
      mem_timeout = timeout_hit;
      if (frz) begin
        // A redirect seen now is re-presented next cycle since EX is held.
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        freeze      = 1'b1;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (hazard) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      ex_vld_p0  <= 1'b0;
      mem_vld_p1 <= 1'b0;
      wb_vld_p2  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mem_req && !mem_ack) begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        default: if (mem_ack || timeout_hit) state <= ST_IDLE;
                 else                        wait_cnt <= wait_cnt + 1'b1;
      endcase
      if (stall_pc)    stall_cnt <= sat_inc(stall_cnt);
      if (flush_if_id) flush_cnt <= sat_inc(flush_cnt);
      if (!frz) begin
        ex_vld_p0  <= ex_next_vld;
        mem_vld_p1 <= ex_vld_p0;
        wb_vld_p2  <= mem_vld_p1;
      end
    end
  end

  // ---- scoreboard data: EX (p0) -> MEM (p1) -> WB (p2) ----
  always_ff @(posedge clk) begin
    if (!frz) begin
      ex_rd_p0  <= id_rd;
      ex_ld_p0  <= id_is_load;
      mem_rd_p1 <= ex_rd_p0;
      wb_rd_p2  <= mem_rd_p1;
    end
  end

endmodule
